// File: rtl/tag_pkg.sv
// Shared widths and FSM state encoding for the serial tag checker family.
package tag_pkg;
  localparam int TAG_W = 32;
  localparam int IDX_W = 5;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;
endpackage

// File: rtl/tag_bit_gen.sv
// One tag bit: y = (x0&r0) ^ (r_i&r_i-1) ^ (x_i&x_i-1) ^ s_i; purely combinational.
// Neighbour bits at index 0 and the running term s are supplied by the caller.
module tag_bit_gen (
  input  logic x0r0,
  input  logic x_cur,
  input  logic x_prev,
  input  logic r_cur,
  input  logic r_prev,
  input  logic s,
  output logic y
);
  assign y = x0r0 ^ (r_cur & r_prev) ^ (x_cur & x_prev) ^ s;
endmodule

// File: rtl/tag_check.sv
// Serial tag verifier: one tag bit per cycle, LSB first; done pulses 33 cycles after start.
// start is ignored while busy; latched operands make later input changes irrelevant.
module tag_check
  import tag_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [TAG_W-1:0] X,
  input  logic [TAG_W-1:0] R,
  input  logic [TAG_W-1:0] T,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [CNT_W-1:0] err_cnt,
  output logic [IDX_W-1:0] err_pos,
  output logic [TAG_W-1:0] Y_calc
);
  state_t           state;
  logic [TAG_W-1:0] x_q, r_q, t_q;
  logic [IDX_W-1:0] idx, idx_m1;
  logic             s_q;
  logic             x_prev, r_prev, y_bit, miss;
  logic [CNT_W-1:0] cnt_nxt;

  // Bit -1 of both operands reads as zero.
  assign idx_m1  = idx - IDX_W'(1);
  assign x_prev  = (idx == '0) ? 1'b0 : x_q[idx_m1];
  assign r_prev  = (idx == '0) ? 1'b0 : r_q[idx_m1];
  assign miss    = y_bit ^ t_q[idx];
  assign cnt_nxt = err_cnt + CNT_W'(miss);

  tag_bit_gen u_bit (
    .x0r0   (x_q[0] & r_q[0]),
    .x_cur  (x_q[idx]),
    .x_prev (x_prev),
    .r_cur  (r_q[idx]),
    .r_prev (r_prev),
    .s      (s_q),
    .y      (y_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      match   <= 1'b0;
      err_cnt <= '0;
      err_pos <= '0;
      Y_calc  <= '0;
      x_q     <= '0;
      r_q     <= '0;
      t_q     <= '0;
      idx     <= '0;
      s_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_q     <= X;
            r_q     <= R;
            t_q     <= T;
            Y_calc  <= '0;
            err_cnt <= '0;
            err_pos <= '0;
            match   <= 1'b0;
            idx     <= '0;
            s_q     <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          Y_calc[idx] <= y_bit;
          err_cnt     <= cnt_nxt;
          // Only the first mismatch sets the position.
          if (miss && (err_cnt == '0))
            err_pos <= idx;
          // S_1 stays zero; the x&r product feeds forward from bit 1 on.
          if (idx != '0)
            s_q <= s_q ^ (x_q[idx] & r_q[idx]);
          if (idx == IDX_W'(TAG_W - 1)) begin
            state <= REPORT;
            done  <= 1'b1;
            match <= (cnt_nxt == '0);
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        REPORT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tag_check.sv
// Directed-vector bench for tag_check: reset, tag vectors, held start, mid-run reset.
module tb_tag_check;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] X = '0, R = '0, T = '0;
  logic        busy, done, match;
  logic [5:0]  err_cnt;
  logic [4:0]  err_pos;
  logic [31:0] Y_calc;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  typedef struct packed {
    logic [31:0] x, r, t, y;
    logic        m;
    logic [5:0]  c;
    logic [4:0]  p;
  } vec_t;

  always #5 clk = ~clk;

  tag_check dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .X       (X),
    .R       (R),
    .T       (T),
    .busy    (busy),
    .done    (done),
    .match   (match),
    .err_cnt (err_cnt),
    .err_pos (err_pos),
    .Y_calc  (Y_calc)
  );

  // Pulse start for one edge, scramble inputs afterwards, wait (bounded) for done.
  task automatic do_check(input logic [31:0] x, input logic [31:0] r,
                          input logic [31:0] t, output int lat);
    @(negedge clk);
    X = x; R = r; T = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0; X = ~x; R = ~r; T = ~t;
    lat = -1;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1;
    vec_cnt++;
    if ({busy, done, match, err_cnt, err_pos, Y_calc} !== '0) begin
      miss_cnt++;
      $display("FAIL reset_state: got busy=%b done=%b match=%b cnt=%0d pos=%0d y=%h, want all zero",
               busy, done, match, err_cnt, err_pos, Y_calc);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_vectors;
    vec_t tbl[9];
    int   lat;
    tbl[0] = '{x:32'h0,        r:32'h0,        t:32'h0,        y:32'h0,        m:1'b1, c:6'd0,  p:5'd0};
    tbl[1] = '{x:32'h1,        r:32'h1,        t:32'hFFFFFFFF, y:32'hFFFFFFFF, m:1'b1, c:6'd0,  p:5'd0};
    tbl[2] = '{x:32'h1,        r:32'h1,        t:32'hFFFFFFFE, y:32'hFFFFFFFF, m:1'b0, c:6'd1,  p:5'd0};
    tbl[3] = '{x:32'hFFFFFFFF, r:32'hFFFFFFFF, t:32'hAAAAAAAB, y:32'hAAAAAAAB, m:1'b1, c:6'd0,  p:5'd0};
    tbl[4] = '{x:32'hFFFFFFFF, r:32'hFFFFFFFF, t:32'h0,        y:32'hAAAAAAAB, m:1'b0, c:6'd17, p:5'd0};
    tbl[5] = '{x:32'hFFFFFFFF, r:32'hFFFFFFFF, t:32'hAAAAA88B, y:32'hAAAAAAAB, m:1'b0, c:6'd2,  p:5'd5};
    tbl[6] = '{x:32'hF0,       r:32'h0,        t:32'hE0,       y:32'hE0,       m:1'b1, c:6'd0,  p:5'd0};
    tbl[7] = '{x:32'h0,        r:32'h0F,       t:32'h0E,       y:32'h0E,       m:1'b1, c:6'd0,  p:5'd0};
    tbl[8] = '{x:32'h6,        r:32'h6,        t:32'h80000004, y:32'h4,        m:1'b0, c:6'd1,  p:5'd31};
    for (int i = 0; i < 9; i++) begin
      do_check(tbl[i].x, tbl[i].r, tbl[i].t, lat);
      vec_cnt++;
      if (lat !== 33) begin
        miss_cnt++;
        $display("FAIL vec%0d_latency: got %0d, want 33", i, lat);
      end
      vec_cnt++;
      if (Y_calc !== tbl[i].y) begin
        miss_cnt++;
        $display("FAIL vec%0d_y_calc: got %h, want %h", i, Y_calc, tbl[i].y);
      end
      vec_cnt++;
      if ({match, err_cnt, err_pos} !== {tbl[i].m, tbl[i].c, tbl[i].p}) begin
        miss_cnt++;
        $display("FAIL vec%0d_result: got match=%b cnt=%0d pos=%0d, want match=%b cnt=%0d pos=%0d",
                 i, match, err_cnt, err_pos, tbl[i].m, tbl[i].c, tbl[i].p);
      end
      vec_cnt++;
      if (busy !== 1'b1) begin
        miss_cnt++;
        $display("FAIL vec%0d_busy_report: got %b, want 1", i, busy);
      end
      @(negedge clk);
      vec_cnt++;
      if ({done, busy, match, Y_calc} !== {2'b00, tbl[i].m, tbl[i].y}) begin
        miss_cnt++;
        $display("FAIL vec%0d_hold: got done=%b busy=%b match=%b y=%h, want done=0 busy=0 match=%b y=%h",
                 i, done, busy, match, Y_calc, tbl[i].m, tbl[i].y);
      end
    end
  endtask

  task automatic test_start_held;
    int done_at[$];
    int idle_seen;
    @(negedge clk);
    X = 32'h1; R = 32'h1; T = 32'hFFFFFFFF; start = 1'b1;
    idle_seen = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 5) begin
        X = 32'h0; R = 32'h0; T = 32'h0;
      end
      if (k == 34 && busy === 1'b0) idle_seen = 1;
      if (done) begin
        done_at.push_back(k);
        vec_cnt++;
        if (done_at.size() == 1 && (Y_calc !== 32'hFFFFFFFF || match !== 1'b1)) begin
          miss_cnt++;
          $display("FAIL held_first_result: got y=%h match=%b, want y=ffffffff match=1", Y_calc, match);
        end else if (done_at.size() == 2 && (Y_calc !== 32'h0 || match !== 1'b1)) begin
          miss_cnt++;
          $display("FAIL held_second_result: got y=%h match=%b, want y=00000000 match=1", Y_calc, match);
        end else if (done_at.size() > 2) begin
          miss_cnt++;
          $display("FAIL held_extra_done: unexpected done at cycle %0d", k);
        end
      end
    end
    start = 1'b0;
    vec_cnt++;
    if (done_at.size() != 2 || done_at[0] != 33 || done_at[1] != 67) begin
      miss_cnt++;
      $display("FAIL held_done_cycles: got %0d pulses first=%0d, want 2 pulses at 33 and 67",
               done_at.size(), (done_at.size() > 0) ? done_at[0] : -1);
    end
    vec_cnt++;
    if (idle_seen != 1) begin
      miss_cnt++;
      $display("FAIL held_idle_gap: busy not low at cycle 34, got flag %0d want 1", idle_seen);
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset_midrun;
    int lat;
    int extra_done;
    @(negedge clk);
    X = 32'hFFFFFFFF; R = 32'hFFFFFFFF; T = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    vec_cnt++;
    if (err_cnt !== 6'd6 || Y_calc !== 32'h000002AB || busy !== 1'b1) begin
      miss_cnt++;
      $display("FAIL midrun_progress: got cnt=%0d y=%h busy=%b, want cnt=6 y=000002ab busy=1",
               err_cnt, Y_calc, busy);
    end
    reset = 1'b0;
    #1;
    vec_cnt++;
    if ({busy, done, match, err_cnt, err_pos, Y_calc} !== '0) begin
      miss_cnt++;
      $display("FAIL midrun_reset_clear: got busy=%b done=%b match=%b cnt=%0d pos=%0d y=%h, want all zero",
               busy, done, match, err_cnt, err_pos, Y_calc);
    end
    extra_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    reset = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    vec_cnt++;
    if (extra_done != 0) begin
      miss_cnt++;
      $display("FAIL aborted_done: got %0d done pulses, want 0", extra_done);
    end
    do_check(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hAAAAAAAB, lat);
    vec_cnt++;
    if (lat !== 33 || match !== 1'b1 || err_cnt !== 6'd0 || Y_calc !== 32'hAAAAAAAB) begin
      miss_cnt++;
      $display("FAIL post_reset_check: got lat=%0d match=%b cnt=%0d y=%h, want lat=33 match=1 cnt=0 y=aaaaaaab",
               lat, match, err_cnt, Y_calc);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_start_held();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
